// File: rtl/vga_scan_timer.sv
// VGA scan timer: pixel-tick divider, h/v scan counters, delayed sync/blank
// outputs for the DAC and a sticky vertical-blank flag for the CPU.
module vga_scan_timer #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vblank_ack_i,
  output logic        pix_en_o,
  output logic [31:0] x_pos_o,
  output logic [31:0] y_pos_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        blank_n_o,
  output logic        frame_start_o,
  output logic        vblank_flag_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  // A zero delay still needs one register stage so the outputs stay glitch-free.
  localparam int STAGES  = (PIPE_DELAY == 0) ? 1 : PIPE_DELAY;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);

  logic [DIV_W-1:0]  div;
  logic              div_last;
  logic [9:0]        h_cnt, v_cnt;
  logic [9:0]        h_nxt, v_nxt;
  logic              hs_raw, vs_raw, bl_raw;
  logic              vblank_set;
  logic [STAGES-1:0] hs_dly_p, vs_dly_p, bl_dly_p;

  always_comb begin
    div_last = (div == DIV_W'(CLK_DIV - 1));
    h_nxt    = h_cnt;
    v_nxt    = v_cnt;
    if (pix_en_o) begin
      h_nxt = (h_cnt == H_LAST) ? 10'd0 : h_cnt + 10'd1;
      if (h_cnt == H_LAST)
        v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
    hs_raw     = !(({1'b0, h_cnt} >= HS_BEG) && ({1'b0, h_cnt} < HS_END));
    vs_raw     = !(({1'b0, v_cnt} >= VS_BEG) && ({1'b0, v_cnt} < VS_END));
    bl_raw     = ({1'b0, h_cnt} < H_VIS) && ({1'b0, v_cnt} < V_VIS);
    vblank_set = pix_en_o && (h_cnt == 10'd0) && ({1'b0, v_cnt} == V_VIS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div           <= '0;
      pix_en_o      <= 1'b0;
      frame_start_o <= 1'b0;
      h_cnt         <= '0;
      v_cnt         <= '0;
      hs_dly_p      <= '1;
      vs_dly_p      <= '1;
      bl_dly_p      <= '0;
      vblank_flag_o <= 1'b0;
    end else begin
      div      <= div_last ? '0 : div + DIV_W'(1);
      pix_en_o <= div_last;
      // h_nxt/v_nxt are the counts visible during the tick that starts next clk
      frame_start_o <= div_last && (h_nxt == 10'd0) && (v_nxt == 10'd0);
      if (pix_en_o) begin
        h_cnt       <= h_nxt;
        v_cnt       <= v_nxt;
        // stage boundary: raw decode -> delay line, advanced once per pixel tick
        hs_dly_p[0] <= hs_raw;
        vs_dly_p[0] <= vs_raw;
        bl_dly_p[0] <= bl_raw;
        for (int i = 1; i < STAGES; i++) begin
          hs_dly_p[i] <= hs_dly_p[i-1];
          vs_dly_p[i] <= vs_dly_p[i-1];
          bl_dly_p[i] <= bl_dly_p[i-1];
        end
      end
      if (vblank_set)
        vblank_flag_o <= 1'b1;
      else if (vblank_ack_i)
        vblank_flag_o <= 1'b0;
    end
  end

  assign x_pos_o   = {22'd0, h_cnt};
  assign y_pos_o   = {22'd0, v_cnt};
  assign hsync_o   = hs_dly_p[STAGES-1];
  assign vsync_o   = vs_dly_p[STAGES-1];
  assign blank_n_o = bl_dly_p[STAGES-1];

endmodule
